fetch_stage: RTL and testbench

- IF stage of the MIPS pipeline. Holds the PC and fetches from instruction memory over a req/ready + rvalid interface, with one request outstanding.
- Loads the IF/ISS pipe register consumed by the issue (decode) stage.
- Obeys stall_fetch/flush_iss from the hazard unit.
- Redirects on a branch taken in EX or a jump resolved in ISS, and drops stale in-flight fetches.

---
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage with single-outstanding imem fetch and IF/ISS pipe register
module fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_fetch_i,
   input  logic        flush_iss_i,
   input  logic        branch_taken_i,
   input  logic [31:0] branch_target_i,
   input  logic        jump_i,
   input  logic [31:0] jump_target_i,
   output logic        imem_req_o,
   output logic [31:0] imem_addr_o,
   input  logic        imem_ready_i,
   input  logic        imem_rvalid_i,
   input  logic [31:0] imem_rdata_i,
   output logic [31:0] instr_iss_o,
   output logic [31:0] pc_plus4_iss_o,
   output logic        valid_iss_o
);
   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;
   state_t      r_state, w_state_nxt;
   logic [31:0] r_pc, w_pc_nxt, r_hold_instr, r_hold_pc4, w_del_instr, w_del_pc4;
   logic        r_drop, w_drop_nxt, w_hold_load, w_deliver;
   logic        w_redirect;
   logic [31:0] w_target, w_pc_plus4;
   assign w_redirect  = branch_taken_i | jump_i;
   assign w_target    = branch_taken_i ? branch_target_i : jump_target_i;
   assign w_pc_plus4  = r_pc + 32'd4;
   assign imem_req_o  = (r_state == S_FETCH);
   assign imem_addr_o = {r_pc[31:2], 2'b00};
   // next-state, next-pc and delivery selection for the fetch FSM
   always_comb begin
      w_state_nxt = r_state;
      w_pc_nxt    = r_pc;
      w_drop_nxt  = r_drop;
      w_hold_load = 1'b0;
      w_deliver   = 1'b0;
      w_del_instr = r_hold_instr;
      w_del_pc4   = r_hold_pc4;
      case (r_state)
         S_FETCH: begin
            if (w_redirect) w_pc_nxt = w_target;
            if (imem_ready_i) begin
               w_state_nxt = S_WAIT;
               w_drop_nxt  = w_redirect;
            end
         end
         S_WAIT: begin
            if (imem_rvalid_i) begin
               w_state_nxt = S_FETCH;
               w_drop_nxt  = 1'b0;
               if (w_redirect) w_pc_nxt = w_target;
               else if (!r_drop) begin
                  if (!stall_fetch_i) begin
                     w_deliver   = 1'b1;
                     w_del_instr = imem_rdata_i;
                     w_del_pc4   = w_pc_plus4;
                     w_pc_nxt    = w_pc_plus4;
                  end else begin
                     w_hold_load = 1'b1;
                     w_state_nxt = S_HOLD;
                  end
               end
            end else if (w_redirect) begin
               w_pc_nxt   = w_target;
               w_drop_nxt = 1'b1;
            end
         end
         S_HOLD: begin
            if (w_redirect) begin
               w_pc_nxt    = w_target;
               w_state_nxt = S_FETCH;
            end else if (!stall_fetch_i) begin
               w_deliver   = 1'b1;
               w_pc_nxt    = w_pc_plus4;
               w_state_nxt = S_FETCH;
            end
         end
         default: w_state_nxt = S_FETCH;
      endcase
   end
   // FSM, PC, drop flag and hold buffer registers
   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= S_FETCH;
         r_pc         <= RESET_PC;
         r_drop       <= 1'b0;
         r_hold_instr <= 32'd0;
         r_hold_pc4   <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         r_pc    <= w_pc_nxt;
         r_drop  <= w_drop_nxt;
         if (w_hold_load) begin
            r_hold_instr <= imem_rdata_i;
            r_hold_pc4   <= w_pc_plus4;
         end
      end
   end
   // IF/ISS pipe register: flush beats stall beats new instruction beats bubble
   always_ff @(posedge clk) begin
      if (reset) begin
         instr_iss_o    <= NOP_INSTR;
         pc_plus4_iss_o <= 32'd0;
         valid_iss_o    <= 1'b0;
      end else if (flush_iss_i) begin
         instr_iss_o <= NOP_INSTR;
         valid_iss_o <= 1'b0;
      end else if (stall_fetch_i) begin
         instr_iss_o <= instr_iss_o;
      end else if (w_deliver) begin
         instr_iss_o    <= w_del_instr;
         pc_plus4_iss_o <= w_del_pc4;
         valid_iss_o    <= 1'b1;
      end else begin
         instr_iss_o <= NOP_INSTR;
         valid_iss_o <= 1'b0;
      end
   end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed self-checking bench for fetch_stage
module tb_fetch_stage;
   logic        clk = 1'b0;
   logic        reset, stall_fetch_i, flush_iss_i, branch_taken_i, jump_i;
   logic [31:0] branch_target_i, jump_target_i;
   logic        imem_req_o, imem_ready_i, imem_rvalid_i;
   logic [31:0] imem_addr_o, imem_rdata_i, instr_iss_o, pc_plus4_iss_o;
   logic        valid_iss_o;
   int          checks = 0;
   int          errors = 0;

   fetch_stage dut (
      .clk(clk), .reset(reset), .stall_fetch_i(stall_fetch_i), .flush_iss_i(flush_iss_i),
      .branch_taken_i(branch_taken_i), .branch_target_i(branch_target_i),
      .jump_i(jump_i), .jump_target_i(jump_target_i),
      .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_ready_i(imem_ready_i),
      .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
      .instr_iss_o(instr_iss_o), .pc_plus4_iss_o(pc_plus4_iss_o), .valid_iss_o(valid_iss_o)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 0; stall_fetch_i = 0; flush_iss_i = 0; branch_taken_i = 0; jump_i = 0;
      branch_target_i = 0; jump_target_i = 0; imem_ready_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
   endtask

   task automatic test_reset();
      idle(); reset = 1; tick(); tick(); reset = 0;
      checks++; if (valid_iss_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %h exp 0", valid_iss_o); end
      checks++; if (instr_iss_o !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp 0", instr_iss_o); end
      checks++; if (pc_plus4_iss_o !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp 0", pc_plus4_iss_o); end
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_req got %h/%h exp 1/0", imem_req_o, imem_addr_o); end
   endtask

   task automatic test_basic();
      imem_ready_i = 1; tick(); imem_ready_i = 0;
      checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL basic_wait_req got %h exp 0", imem_req_o); end
      imem_rvalid_i = 1; imem_rdata_i = 32'h2008_0005; tick(); imem_rvalid_i = 0;
      checks++; if (valid_iss_o !== 1'b1 || instr_iss_o !== 32'h2008_0005) begin errors++; $display("FAIL basic_instr got %h/%h exp 1/20080005", valid_iss_o, instr_iss_o); end
      checks++; if (pc_plus4_iss_o !== 32'h4) begin errors++; $display("FAIL basic_pc4 got %h exp 4", pc_plus4_iss_o); end
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin errors++; $display("FAIL basic_next_addr got %h/%h exp 1/4", imem_req_o, imem_addr_o); end
   endtask

   task automatic test_stall();
      stall_fetch_i = 1; imem_ready_i = 1; tick(); imem_ready_i = 0;
      checks++; if (valid_iss_o !== 1'b1 || instr_iss_o !== 32'h2008_0005) begin errors++; $display("FAIL stall_hold1 got %h/%h exp 1/20080005", valid_iss_o, instr_iss_o); end
      imem_rvalid_i = 1; imem_rdata_i = 32'hAAAA_0001; tick(); imem_rvalid_i = 0; imem_rdata_i = 0;
      checks++; if (valid_iss_o !== 1'b1 || instr_iss_o !== 32'h2008_0005 || pc_plus4_iss_o !== 32'h4) begin errors++; $display("FAIL stall_hold2 got %h/%h/%h exp 1/20080005/4", valid_iss_o, instr_iss_o, pc_plus4_iss_o); end
      checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_hold_req got %h exp 0", imem_req_o); end
      tick();
      checks++; if (imem_req_o !== 1'b0 || instr_iss_o !== 32'h2008_0005) begin errors++; $display("FAIL stall_hold3 got %h/%h exp 0/20080005", imem_req_o, instr_iss_o); end
      stall_fetch_i = 0; tick();
      checks++; if (valid_iss_o !== 1'b1 || instr_iss_o !== 32'hAAAA_0001 || pc_plus4_iss_o !== 32'h8) begin errors++; $display("FAIL stall_release got %h/%h/%h exp 1/aaaa0001/8", valid_iss_o, instr_iss_o, pc_plus4_iss_o); end
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h8) begin errors++; $display("FAIL stall_next_addr got %h/%h exp 1/8", imem_req_o, imem_addr_o); end
   endtask

   task automatic test_bubble();
      tick();
      checks++; if (valid_iss_o !== 1'b0 || instr_iss_o !== 32'h0 || pc_plus4_iss_o !== 32'h8) begin errors++; $display("FAIL bubble got %h/%h/%h exp 0/0/8", valid_iss_o, instr_iss_o, pc_plus4_iss_o); end
   endtask

   task automatic test_branch_wait();
      imem_ready_i = 1; tick(); imem_ready_i = 0;
      branch_taken_i = 1; branch_target_i = 32'h100; tick(); branch_taken_i = 0;
      checks++; if (imem_req_o !== 1'b0 || valid_iss_o !== 1'b0) begin errors++; $display("FAIL br_wait got %h/%h exp 0/0", imem_req_o, valid_iss_o); end
      imem_rvalid_i = 1; imem_rdata_i = 32'hDEAD_BEEF; tick(); imem_rvalid_i = 0;
      checks++; if (valid_iss_o !== 1'b0 || instr_iss_o !== 32'h0) begin errors++; $display("FAIL br_discard got %h/%h exp 0/0", valid_iss_o, instr_iss_o); end
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h100) begin errors++; $display("FAIL br_addr got %h/%h exp 1/100", imem_req_o, imem_addr_o); end
      imem_ready_i = 1; tick(); imem_ready_i = 0;
      checks++; if (valid_iss_o !== 1'b0) begin errors++; $display("FAIL br_wait2 got %h exp 0", valid_iss_o); end
      imem_rvalid_i = 1; imem_rdata_i = 32'h1111_2222; tick(); imem_rvalid_i = 0;
      checks++; if (valid_iss_o !== 1'b1 || instr_iss_o !== 32'h1111_2222 || pc_plus4_iss_o !== 32'h104) begin errors++; $display("FAIL br_deliver got %h/%h/%h exp 1/11112222/104", valid_iss_o, instr_iss_o, pc_plus4_iss_o); end
   endtask

   task automatic test_dual_redirect();
      branch_taken_i = 1; branch_target_i = 32'h200; jump_i = 1; jump_target_i = 32'h300; flush_iss_i = 1;
      tick(); idle();
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h200) begin errors++; $display("FAIL dual_addr got %h/%h exp 1/200", imem_req_o, imem_addr_o); end
      checks++; if (valid_iss_o !== 1'b0 || instr_iss_o !== 32'h0 || pc_plus4_iss_o !== 32'h104) begin errors++; $display("FAIL dual_flush got %h/%h/%h exp 0/0/104", valid_iss_o, instr_iss_o, pc_plus4_iss_o); end
   endtask

   task automatic test_redirect_accept();
      imem_ready_i = 1; jump_i = 1; jump_target_i = 32'h300; tick(); idle();
      checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL racc_wait got %h exp 0", imem_req_o); end
      imem_rvalid_i = 1; imem_rdata_i = 32'h5555_5555; tick(); idle();
      checks++; if (valid_iss_o !== 1'b0 || imem_req_o !== 1'b1 || imem_addr_o !== 32'h300) begin errors++; $display("FAIL racc_drop got %h/%h/%h exp 0/1/300", valid_iss_o, imem_req_o, imem_addr_o); end
   endtask

   task automatic test_wrap();
      branch_taken_i = 1; branch_target_i = 32'hFFFF_FFFC; tick(); idle();
      checks++; if (imem_addr_o !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr got %h exp fffffffc", imem_addr_o); end
      imem_ready_i = 1; tick(); imem_ready_i = 0;
      imem_rvalid_i = 1; imem_rdata_i = 32'h3333_0000; tick(); imem_rvalid_i = 0;
      checks++; if (valid_iss_o !== 1'b1 || instr_iss_o !== 32'h3333_0000 || pc_plus4_iss_o !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h/%h/%h exp 1/33330000/0", valid_iss_o, instr_iss_o, pc_plus4_iss_o); end
      checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL wrap_next got %h exp 0", imem_addr_o); end
   endtask

   task automatic test_flush_stall();
      imem_ready_i = 1; tick(); imem_ready_i = 0;
      imem_rvalid_i = 1; imem_rdata_i = 32'h1234_5678; tick(); imem_rvalid_i = 0;
      checks++; if (valid_iss_o !== 1'b1 || instr_iss_o !== 32'h1234_5678) begin errors++; $display("FAIL fs_load got %h/%h exp 1/12345678", valid_iss_o, instr_iss_o); end
      flush_iss_i = 1; stall_fetch_i = 1; tick(); idle();
      checks++; if (valid_iss_o !== 1'b0 || instr_iss_o !== 32'h0 || pc_plus4_iss_o !== 32'h4) begin errors++; $display("FAIL fs_flush got %h/%h/%h exp 0/0/4", valid_iss_o, instr_iss_o, pc_plus4_iss_o); end
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h4) begin errors++; $display("FAIL fs_pc got %h/%h exp 1/4", imem_req_o, imem_addr_o); end
   endtask

   task automatic test_align();
      branch_taken_i = 1; branch_target_i = 32'h0000_0013; tick(); idle();
      checks++; if (imem_addr_o !== 32'h10) begin errors++; $display("FAIL align got %h exp 10", imem_addr_o); end
   endtask

   task automatic test_reset_mid_wait();
      imem_ready_i = 1; tick(); imem_ready_i = 0;
      reset = 1; tick(); reset = 0;
      checks++; if (valid_iss_o !== 1'b0 || instr_iss_o !== 32'h0 || pc_plus4_iss_o !== 32'h0) begin errors++; $display("FAIL rst_mid got %h/%h/%h exp 0/0/0", valid_iss_o, instr_iss_o, pc_plus4_iss_o); end
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_mid_req got %h/%h exp 1/0", imem_req_o, imem_addr_o); end
      imem_rvalid_i = 1; imem_rdata_i = 32'h7777_7777; tick(); idle();
      checks++; if (valid_iss_o !== 1'b0 || instr_iss_o !== 32'h0) begin errors++; $display("FAIL rst_late_rvalid got %h/%h exp 0/0", valid_iss_o, instr_iss_o); end
      checks++; if (imem_req_o !== 1'b1 || imem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_late_state got %h/%h exp 1/0", imem_req_o, imem_addr_o); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_stall();
      test_bubble();
      test_branch_wait();
      test_dual_redirect();
      test_redirect_accept();
      test_wrap();
      test_flush_stall();
      test_align();
      test_reset_mid_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
